// File: rtl/conv_core_if.sv
// rtl/conv_core_if.sv - start/fetch/result signal bundle between conv_core and its host
interface conv_core_if #(
    parameter int IFM_WIDTH    = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int DATA_WIDTH   = 16
);
    logic                    start_conv;
    logic [IFM_WIDTH-1:0]    ifm;
    logic [WEIGHT_WIDTH-1:0] wgt;
    logic                    ifm_read;
    logic                    wgt_read;
    logic                    out_valid;
    logic                    end_conv;
    logic [DATA_WIDTH-1:0]   data_output;

    modport master (
        output start_conv, ifm, wgt,
        input  ifm_read, wgt_read, out_valid, end_conv, data_output
    );

    modport slave (
        input  start_conv, ifm, wgt,
        output ifm_read, wgt_read, out_valid, end_conv, data_output
    );
endinterface

// File: rtl/conv_core.sv
// rtl/conv_core.sv - serial-MAC convolution engine: load weights, load IFM, stream OFM words
// Optional CONV_SATURATE_EN: saturate results to signed DATA_WIDTH instead of wrapping.
module conv_core #(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int IFM_WIDTH    = 8,
    parameter int IFM_SIZE     = 64,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int PAD          = 0,
    parameter int RELU         = 1,
    parameter int FIFO_SIZE    = (IFM_SIZE - KERNEL_SIZE + 2 * PAD) / STRIDE + 1,
    parameter int CI           = 3,
    parameter int CO           = 8
) (
    input  logic       clk1,
    input  logic       rst_n,
    conv_core_if.slave bus
);
    localparam int NW   = CO * CI * KERNEL_SIZE * KERNEL_SIZE;
    localparam int NI   = CI * IFM_SIZE * IFM_SIZE;
    localparam int NMAC = CI * KERNEL_SIZE * KERNEL_SIZE;
    localparam int OFM  = FIFO_SIZE;
    localparam int WAW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int IAW  = (NI > 1) ? $clog2(NI) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_I, S_COMPUTE, S_DONE} state_t;

    state_t r_state, w_next;
    logic [31:0] r_cnt;
    logic        r_wpend, r_ipend;
    logic [WAW-1:0] r_wcap_addr;
    logic [IAW-1:0] r_icap_addr;
    logic [31:0] r_mk, r_ci, r_ky, r_kx, r_co, r_oy, r_ox;
    logic signed [31:0] r_acc;
    logic        r_valid, r_end;
    logic [DATA_WIDTH-1:0] r_data;
    logic signed [WEIGHT_WIDTH-1:0] r_wmem [NW];
    logic [IFM_WIDTH-1:0]           r_imem [NI];

    logic        w_wgt_read, w_ifm_read, w_last_mac, w_last_pix, w_in_range;
    logic signed [31:0] w_iy, w_ix, w_prod, w_acc_next, w_post;
    logic [IAW-1:0] w_iaddr;
    logic [WAW-1:0] w_waddr;
    logic [IFM_WIDTH-1:0] w_pix;
    logic signed [WEIGHT_WIDTH-1:0] w_wt;
    logic [DATA_WIDTH-1:0] w_result;

    assign w_last_mac = (r_mk == NMAC);
    assign w_last_pix = (r_co == CO - 1) && (r_oy == OFM - 1) && (r_ox == OFM - 1);

    always_ff @(posedge clk1) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_wgt_read = 1'b0;
        w_ifm_read = 1'b0;
        case (r_state)
            S_IDLE:    if (bus.start_conv) w_next = S_LOAD_W;
            S_LOAD_W: begin
                w_wgt_read = 1'b1;
                if (r_cnt == NW - 1) w_next = S_LOAD_I;
            end
            S_LOAD_I: begin
                w_ifm_read = 1'b1;
                if (r_cnt == NI - 1) w_next = S_COMPUTE;
            end
            S_COMPUTE: if (w_last_mac && w_last_pix) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Tap address: padded coordinates outside the IFM read as zero.
    always_comb begin
        w_iy       = $signed(r_oy * STRIDE + r_ky) - PAD;
        w_ix       = $signed(r_ox * STRIDE + r_kx) - PAD;
        w_in_range = (w_iy >= 0) && (w_iy < IFM_SIZE) && (w_ix >= 0) && (w_ix < IFM_SIZE);
        w_iaddr    = w_in_range
                   ? IAW'((r_ci * IFM_SIZE + $unsigned(w_iy)) * IFM_SIZE + $unsigned(w_ix))
                   : '0;
        w_waddr    = WAW'(((r_co * CI + r_ci) * KERNEL_SIZE + r_ky) * KERNEL_SIZE + r_kx);
        w_pix      = w_in_range ? r_imem[w_iaddr] : '0;
        w_wt       = r_wmem[w_waddr];
        w_prod     = $signed({{(32 - IFM_WIDTH){1'b0}}, w_pix})
                   * $signed({{(32 - WEIGHT_WIDTH){w_wt[WEIGHT_WIDTH-1]}}, w_wt});
        w_acc_next = r_acc + w_prod;
        w_post     = ((RELU != 0) && (w_acc_next < 0)) ? 32'sd0 : w_acc_next;
    end

`ifdef CONV_SATURATE_EN
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (DATA_WIDTH - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -SAT_MAX - 32'sd1;
    always_comb begin
        if (w_post > SAT_MAX)      w_result = DATA_WIDTH'(SAT_MAX);
        else if (w_post < SAT_MIN) w_result = DATA_WIDTH'(SAT_MIN);
        else                       w_result = DATA_WIDTH'(w_post);
    end
`else
    assign w_result = DATA_WIDTH'(w_post);
`endif

    // Storage has no reset; the pending flags gate every write.
    always_ff @(posedge clk1) begin
        if (r_wpend) r_wmem[r_wcap_addr] <= $signed(bus.wgt);
        if (r_ipend) r_imem[r_icap_addr] <= bus.ifm;
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_cnt <= '0;  r_wpend <= 1'b0;  r_ipend <= 1'b0;
            r_wcap_addr <= '0;  r_icap_addr <= '0;
            r_mk <= '0;  r_ci <= '0;  r_ky <= '0;  r_kx <= '0;
            r_co <= '0;  r_oy <= '0;  r_ox <= '0;
            r_acc <= '0;  r_valid <= 1'b0;  r_end <= 1'b0;  r_data <= '0;
        end else begin
            r_wpend     <= (r_state == S_LOAD_W);
            r_ipend     <= (r_state == S_LOAD_I);
            r_wcap_addr <= WAW'(r_cnt);
            r_icap_addr <= IAW'(r_cnt);
            r_valid     <= 1'b0;
            r_end       <= (r_state == S_DONE);
            case (r_state)
                S_LOAD_W: r_cnt <= (r_cnt == NW - 1) ? '0 : r_cnt + 1;
                S_LOAD_I: r_cnt <= r_cnt + 1;
                S_COMPUTE: begin
                    // mk==0 is a setup slot so the last IFM pixel lands before the first MAC.
                    if (r_mk == '0) begin
                        r_acc <= '0;
                        r_mk  <= 32'd1;
                    end else if (w_last_mac) begin
                        r_acc   <= w_acc_next;
                        r_mk    <= '0;
                        r_ci    <= '0;  r_ky <= '0;  r_kx <= '0;
                        r_valid <= 1'b1;
                        r_data  <= w_result;
                        if (r_ox == OFM - 1) begin
                            r_ox <= '0;
                            if (r_oy == OFM - 1) begin
                                r_oy <= '0;
                                r_co <= r_co + 1;
                            end else begin
                                r_oy <= r_oy + 1;
                            end
                        end else begin
                            r_ox <= r_ox + 1;
                        end
                    end else begin
                        r_acc <= w_acc_next;
                        r_mk  <= r_mk + 1;
                        if (r_kx == KERNEL_SIZE - 1) begin
                            r_kx <= '0;
                            if (r_ky == KERNEL_SIZE - 1) begin
                                r_ky <= '0;
                                r_ci <= r_ci + 1;
                            end else begin
                                r_ky <= r_ky + 1;
                            end
                        end else begin
                            r_kx <= r_kx + 1;
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;  r_mk <= '0;  r_acc <= '0;
                    r_ci <= '0;  r_ky <= '0;  r_kx <= '0;
                    r_co <= '0;  r_oy <= '0;  r_ox <= '0;
                end
            endcase
        end
    end

    assign bus.wgt_read    = w_wgt_read;
    assign bus.ifm_read    = w_ifm_read;
    assign bus.out_valid   = r_valid;
    assign bus.end_conv    = r_end;
    assign bus.data_output = r_data;
endmodule

// File: tb/tb_conv_core.sv
// tb/tb_conv_core.sv - randomized self-checking bench for conv_core against a loop-nest reference
module tb_conv_core;
    localparam int DW = 16, WW = 8, IW = 8;
    localparam int IFM = 5, K = 3, S = 2, P = 1, RL = 1, NCI = 2, NCO = 2;
    localparam int OFM = (IFM - K + 2 * P) / S + 1;
    localparam int NW = NCO * NCI * K * K;
    localparam int NI = NCI * IFM * IFM;
    localparam int BUDGET = 3000;

    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    logic signed [WW-1:0] tb_w [NW];
    logic [IW-1:0]        tb_i [NI];
    logic [DW-1:0]        exp_q [$];

    conv_core_if #(.IFM_WIDTH(IW), .WEIGHT_WIDTH(WW), .DATA_WIDTH(DW)) bus ();

    conv_core #(
        .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .IFM_WIDTH(IW), .IFM_SIZE(IFM),
        .KERNEL_SIZE(K), .STRIDE(S), .PAD(P), .RELU(RL), .FIFO_SIZE(OFM),
        .CI(NCI), .CO(NCO)
    ) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk1 = ~clk1;

    // Host memory model: each fetch strobe is answered with data in the following cycle.
    initial begin
        bit w_pend = 1'b0, i_pend = 1'b0;
        int wi = 0, ii = 0;
        bus.wgt = '0;
        bus.ifm = '0;
        forever begin
            @(negedge clk1);
            if (w_pend) begin bus.wgt = tb_w[wi]; wi++; end
            else        bus.wgt = 8'($urandom);
            if (i_pend) begin bus.ifm = tb_i[ii]; ii++; end
            else        bus.ifm = 8'($urandom);
            w_pend = bus.wgt_read;
            i_pend = bus.ifm_read;
            if (!w_pend) wi = 0;
            if (!i_pend) ii = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
        end
    endtask

    task automatic build_exp();
        longint acc;
        int iy, ix;
        exp_q.delete();
        for (int co = 0; co < NCO; co++)
            for (int oy = 0; oy < OFM; oy++)
                for (int ox = 0; ox < OFM; ox++) begin
                    acc = 0;
                    for (int ci = 0; ci < NCI; ci++)
                        for (int ky = 0; ky < K; ky++)
                            for (int kx = 0; kx < K; kx++) begin
                                iy = oy * S + ky - P;
                                ix = ox * S + kx - P;
                                if (iy >= 0 && iy < IFM && ix >= 0 && ix < IFM)
                                    acc += int'(tb_i[(ci * IFM + iy) * IFM + ix])
                                         * int'(tb_w[((co * NCI + ci) * K + ky) * K + kx]);
                            end
                    if (RL != 0 && acc < 0) acc = 0;
`ifdef CONV_SATURATE_EN
                    if (acc > 32767) acc = 32767;
                    if (acc < -32768) acc = -32768;
`endif
                    exp_q.push_back(DW'(acc));
                end
    endtask

    task automatic fill(input int mode, input int iv, input int wv);
        for (int n = 0; n < NW; n++) tb_w[n] = (mode == 0) ? WW'(wv) : WW'($urandom);
        for (int n = 0; n < NI; n++) tb_i[n] = (mode == 0) ? IW'(iv) : IW'($urandom);
    endtask

    task automatic start_pulse();
        @(negedge clk1);
        bus.start_conv = 1'b1;
        @(negedge clk1);
        bus.start_conv = 1'b0;
    endtask

    task automatic do_run(input string name, input bit poke);
        int n_w = 0, n_i = 0, n_out = 0, n_end = 0, last_v = -10, end_cyc = -1;
        bit poked = 1'b0;
        build_exp();
        start_pulse();
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (cyc > 0) @(negedge clk1);
            if (cyc == 0) chk({name, "_wgt_read_first"}, 32'(bus.wgt_read), 32'd1);
            bus.start_conv = 1'b0;
            if (poke && !poked && bus.ifm_read) begin
                bus.start_conv = 1'b1;
                poked = 1'b1;
            end
            n_w += int'(bus.wgt_read);
            n_i += int'(bus.ifm_read);
            if (bus.out_valid) begin
                if (n_out < exp_q.size())
                    chk($sformatf("%s_out%0d", name, n_out), 32'(bus.data_output), 32'(exp_q[n_out]));
                n_out++;
                last_v = cyc;
            end
            if (bus.end_conv) begin
                n_end++;
                end_cyc = cyc;
            end
            if (end_cyc >= 0 && cyc >= end_cyc + 4) break;
        end
        bus.start_conv = 1'b0;
        chk({name, "_n_out"}, 32'(n_out), 32'(exp_q.size()));
        chk({name, "_wgt_cycles"}, 32'(n_w), 32'(NW));
        chk({name, "_ifm_cycles"}, 32'(n_i), 32'(NI));
        chk({name, "_n_end"}, 32'(n_end), 32'd1);
        chk({name, "_end_after_last"}, 32'(end_cyc), 32'(last_v + 1));
    endtask

    task automatic do_abort();
        int n_out = 0, seen = 0;
        start_pulse();
        for (int cyc = 0; cyc < BUDGET && n_out < 2; cyc++) begin
            @(negedge clk1);
            if (bus.out_valid) n_out++;
        end
        chk("abort_reached_compute", 32'(n_out), 32'd2);
        rst_n = 1'b0;
        @(negedge clk1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_end_conv", 32'(bus.end_conv), 32'd0);
        chk("abort_data", 32'(bus.data_output), 32'd0);
        chk("abort_wgt_read", 32'(bus.wgt_read), 32'd0);
        chk("abort_ifm_read", 32'(bus.ifm_read), 32'd0);
        rst_n = 1'b1;
        repeat (80) begin
            @(negedge clk1);
            seen += int'(bus.out_valid) + int'(bus.end_conv) + int'(bus.wgt_read) + int'(bus.ifm_read);
        end
        chk("abort_quiet", 32'(seen), 32'd0);
    endtask

    initial begin
        bus.start_conv = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_end_conv", 32'(bus.end_conv), 32'd0);
        chk("rst_data", 32'(bus.data_output), 32'd0);
        chk("rst_wgt_read", 32'(bus.wgt_read), 32'd0);
        chk("rst_ifm_read", 32'(bus.ifm_read), 32'd0);
        rst_n = 1'b1;
        @(negedge clk1);

        fill(0, 1, 1);     do_run("ones", 1'b0);
        fill(1, 0, 0);     do_run("rand_a", 1'b0);
        fill(1, 0, 0);     do_run("rand_b", 1'b0);
        fill(0, 255, 127); do_run("max", 1'b0);
        fill(0, 1, -1);    do_run("neg", 1'b0);
        fill(1, 0, 0);     do_abort();
        fill(1, 0, 0);     do_run("after_abort", 1'b0);
        fill(1, 0, 0);     do_run("poke_start", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
